// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: hazard/memory inputs from the pipeline and the
// stall/flush controls plus counters going back to it.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic [4:0]       ID_rs;
  logic [4:0]       ID_rt;
  logic             ID_uses_rt;
  logic             EX_MemRead;
  logic [4:0]       EX_rt;
  logic             EX_redirect;
  logic             mem_req;
  logic             mem_ready;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IFIDFlush;
  logic             IDEXFlush;
  logic             mem_stall;
  logic             timeout_err;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output ID_rs, ID_rt, ID_uses_rt, EX_MemRead, EX_rt, EX_redirect, mem_req, mem_ready,
    input  PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, mem_stall, timeout_err,
    input  stall_count, flush_count
  );

  modport slave (
    input  ID_rs, ID_rt, ID_uses_rt, EX_MemRead, EX_rt, EX_redirect, mem_req, mem_ready,
    output PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, mem_stall, timeout_err,
    output stall_count, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, EX redirects and
// data-memory wait states, with saturating stall/flush counters and a timeout flag.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus_io
);

  typedef enum logic [1:0] {StRun, StMemWait, StErr} state_e;

  localparam logic [7:0]       WaitLast = 8'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntOne   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             flush_pend_q, flush_pend_d;
  logic             timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use, flush_req, freeze;
  logic pc_write, ifid_write, ifid_flush, idex_flush, mem_stall;

  always_comb begin
    load_use  = bus_io.EX_MemRead && (bus_io.EX_rt != 5'd0) &&
                ((bus_io.EX_rt == bus_io.ID_rs) ||
                 (bus_io.ID_uses_rt && (bus_io.EX_rt == bus_io.ID_rt)));
    flush_req = bus_io.EX_redirect | flush_pend_q;
    freeze    = (state_q != StRun) | (bus_io.mem_req & ~bus_io.mem_ready);
  end

  // Mealy outputs; a pending redirect never flushes a load-use stall's wrong-path instruction late.
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    mem_stall  = 1'b0;
    if (!rst) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end else if (freeze) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      mem_stall  = 1'b1;
    end else if (flush_req) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      StRun: begin
        if (bus_io.mem_req && !bus_io.mem_ready) begin
          state_d    = StMemWait;
          wait_cnt_d = 8'd1;
        end
      end
      StMemWait: begin
        // mem_req is deliberately ignored here; only ready ends the wait.
        if (bus_io.mem_ready) begin
          state_d    = StRun;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == WaitLast) begin
          state_d       = StErr;
          timeout_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      StErr:   timeout_err_d = 1'b1;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    flush_pend_d = flush_pend_q;
    if (bus_io.EX_redirect && freeze) begin
      flush_pend_d = 1'b1;
    end else if (flush_req && !freeze) begin
      flush_pend_d = 1'b0;
    end
    stall_cnt_d = stall_cnt_q;
    if (!ifid_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CntOne;
    end
    flush_cnt_d = flush_cnt_q;
    if (ifid_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StRun;
      wait_cnt_q    <= 8'd0;
      flush_pend_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      flush_pend_q  <= flush_pend_d;
      timeout_err_q <= timeout_err_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign bus_io.PCWrite     = pc_write;
  assign bus_io.IFIDWrite   = ifid_write;
  assign bus_io.IFIDFlush   = ifid_flush;
  assign bus_io.IDEXFlush   = idex_flush;
  assign bus_io.mem_stall   = mem_stall;
  assign bus_io.timeout_err = timeout_err_q;
  assign bus_io.stall_count = stall_cnt_q;
  assign bus_io.flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl against a cycle-level
// behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MemTimeout = 4;
  localparam int unsigned CntW       = 4;
  localparam int          CntMax     = (1 << CntW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CntW)) bus ();

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT(MemTimeout),
    .CNT_W      (CntW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  int chk_cnt = 0;
  int err_cnt = 0;

  // Model state: whether memory is being waited on, how long, error latch,
  // an owed redirect and the two event tallies.
  bit m_wait, m_err, m_owed;
  int m_wait_cycles, m_stalls, m_flushes;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.ID_rs       = 5'd0;
    bus.ID_rt       = 5'd0;
    bus.ID_uses_rt  = 1'b0;
    bus.EX_MemRead  = 1'b0;
    bus.EX_rt       = 5'd0;
    bus.EX_redirect = 1'b0;
    bus.mem_req     = 1'b0;
    bus.mem_ready   = 1'b0;
  endtask

  task automatic run_cycle();
    bit lu, owed, frozen;
    bit e_pc, e_ifw, e_iff, e_idf, e_ms;
    @(negedge clk);
    lu = bus.EX_MemRead && (bus.EX_rt != 5'd0) &&
         ((bus.EX_rt == bus.ID_rs) || (bus.ID_uses_rt && (bus.EX_rt == bus.ID_rt)));
    owed   = bus.EX_redirect || m_owed;
    frozen = m_err || m_wait || (bus.mem_req && !bus.mem_ready);
    if (!rst)        {e_pc, e_ifw, e_iff, e_idf, e_ms} = 5'b00010;
    else if (frozen) {e_pc, e_ifw, e_iff, e_idf, e_ms} = 5'b00001;
    else if (owed)   {e_pc, e_ifw, e_iff, e_idf, e_ms} = 5'b11110;
    else if (lu)     {e_pc, e_ifw, e_iff, e_idf, e_ms} = 5'b00010;
    else             {e_pc, e_ifw, e_iff, e_idf, e_ms} = 5'b11000;
    check_eq("PCWrite", 32'(bus.PCWrite), 32'(e_pc));
    check_eq("IFIDWrite", 32'(bus.IFIDWrite), 32'(e_ifw));
    check_eq("IFIDFlush", 32'(bus.IFIDFlush), 32'(e_iff));
    check_eq("IDEXFlush", 32'(bus.IDEXFlush), 32'(e_idf));
    check_eq("mem_stall", 32'(bus.mem_stall), 32'(e_ms));
    check_eq("timeout_err", 32'(bus.timeout_err), 32'(m_err));
    check_eq("stall_count", 32'(bus.stall_count), 32'(m_stalls));
    check_eq("flush_count", 32'(bus.flush_count), 32'(m_flushes));
    @(posedge clk);
    if (!rst) begin
      m_wait = 0; m_err = 0; m_owed = 0;
      m_wait_cycles = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (!e_ifw && m_stalls < CntMax) m_stalls++;
      if (e_iff && m_flushes < CntMax) m_flushes++;
      if (frozen && bus.EX_redirect) m_owed = 1;
      else if (!frozen)              m_owed = 0;
      if (frozen && !m_err) begin
        if (bus.mem_ready) begin
          m_wait = 0;
          m_wait_cycles = 0;
        end else begin
          m_wait_cycles++;
          if (m_wait_cycles >= MemTimeout) begin
            m_err  = 1;
            m_wait = 0;
          end else begin
            m_wait = 1;
          end
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    run_cycle();
    rst = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    m_wait = 0; m_err = 0; m_owed = 0;
    m_wait_cycles = 0; m_stalls = 0; m_flushes = 0;
    run_cycle();
    run_cycle();
    rst = 1'b1;

    // Load-use on rs.
    bus.EX_MemRead = 1'b1; bus.EX_rt = 5'd5; bus.ID_rs = 5'd5;
    run_cycle();
    check_eq("lu_stall_cnt", 32'(bus.stall_count), 32'd1);

    // Load to $0 never stalls.
    idle_inputs();
    bus.EX_MemRead = 1'b1;
    run_cycle();

    // Redirect beats load-use.
    bus.EX_rt = 5'd7; bus.ID_rt = 5'd7; bus.ID_uses_rt = 1'b1; bus.EX_redirect = 1'b1;
    run_cycle();
    check_eq("redir_flush_cnt", 32'(bus.flush_count), 32'd1);

    // Redirect during a memory wait is applied once after the freeze.
    idle_inputs();
    bus.mem_req = 1'b1;
    run_cycle();
    bus.EX_redirect = 1'b1;
    run_cycle();
    bus.EX_redirect = 1'b0;
    run_cycle();
    bus.mem_ready = 1'b1;
    run_cycle();
    check_eq("wait_stall_cnt", 32'(bus.stall_count), 32'd5);
    idle_inputs();
    #1;
    check_eq("pend_flush_now", 32'(bus.IFIDFlush), 32'd1);
    run_cycle();
    check_eq("pend_flush_cnt", 32'(bus.flush_count), 32'd2);
    run_cycle();
    run_cycle();
    check_eq("pend_flush_once", 32'(bus.flush_count), 32'd2);

    // Timeout into ERR, ready does not release it, reset does.
    do_reset();
    bus.mem_req = 1'b1;
    for (int i = 0; i < 6; i++) run_cycle();
    check_eq("to_err_set", 32'(bus.timeout_err), 32'd1);
    bus.mem_ready = 1'b1;
    run_cycle();
    run_cycle();
    check_eq("to_err_hold", 32'(bus.timeout_err), 32'd1);
    check_eq("to_stall_hold", 32'(bus.mem_stall), 32'd1);
    do_reset();
    idle_inputs();
    #1;
    check_eq("to_clr_err", 32'(bus.timeout_err), 32'd0);
    check_eq("to_clr_stall", 32'(bus.stall_count), 32'd0);
    check_eq("to_clr_flush", 32'(bus.flush_count), 32'd0);
    check_eq("to_clr_mstall", 32'(bus.mem_stall), 32'd0);
    run_cycle();

    // Reset mid-wait drops the wait and an owed redirect.
    bus.mem_req = 1'b1;
    run_cycle();
    bus.EX_redirect = 1'b1;
    run_cycle();
    bus.EX_redirect = 1'b0;
    rst = 1'b0;
    run_cycle();
    rst = 1'b1;
    idle_inputs();
    run_cycle();
    run_cycle();
    check_eq("rst_wait_noflush", 32'(bus.flush_count), 32'd0);

    // Saturation of the stall counter.
    do_reset();
    bus.EX_MemRead = 1'b1; bus.EX_rt = 5'd3; bus.ID_rs = 5'd3;
    for (int i = 0; i < 20; i++) run_cycle();
    check_eq("stall_sat", 32'(bus.stall_count), 32'(CntMax));

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst             = ($urandom_range(99) >= 2);
      bus.ID_rs       = 5'($urandom_range(3));
      bus.ID_rt       = 5'($urandom_range(3));
      bus.ID_uses_rt  = 1'($urandom_range(1));
      bus.EX_MemRead  = 1'($urandom_range(1));
      bus.EX_rt       = 5'($urandom_range(3));
      bus.EX_redirect = ($urandom_range(7) == 0);
      bus.mem_req     = ($urandom_range(3) == 0);
      bus.mem_ready   = 1'($urandom_range(1));
      run_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
